data_mem_responder: RTL

Multi-cycle responder for the pipeline's data-memory port. It models a wait-stated data RAM: it latches a read or write request from the CPU, holds it for a programmable latency, then returns a one-cycle mem_ready strobe (plus read data) that releases the pipeline's memory-stage stall. It sits between the pipeline's data_addr/data_in/mem_read/mem_write outputs and its data_out input. It also adds a ready/error handshake.

---
 rtl/data_mem_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Wait-stated data RAM responder: latches a CPU read/write, holds it LATENCY cycles,
// then returns a one-cycle mem_ready strobe with read data or an error flag.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic          access;
    logic          req_err;
    logic          ram_we;
    logic [IW-1:0] idx;

    assign idx     = addr_q[IW+1:2];
    // Upper address bits only feed the range check, so out-of-range never aliases.
    assign req_err = (rd_q & wr_q) | (addr_q[1:0] != 2'b00) | (addr_q[31:IW+2] != '0);
    assign access  = (state_q == S_WAIT) && (cnt_q == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mem_read | mem_write) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        if (state_q == S_IDLE && (mem_read | mem_write)) begin
            addr_d  = data_addr;
            wdata_d = data_in;
            rd_d    = mem_read;
            wr_d    = mem_write;
            cnt_d   = CNT_INIT;
        end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (access) begin
            ready_d = 1'b1;
            err_d   = req_err;
            if (req_err) begin
                rdata_d = 32'd0;
            end else if (rd_q) begin
                rdata_d = mem_q[idx];
            end else begin
                ram_we = wr_q;
            end
        end
    end

    always_comb begin
        data_out  = rdata_q;
        mem_ready = ready_q;
        mem_err   = err_q;
    end

endmodule
